// File: rtl/exec_alu_cc.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_cc
// Purpose  : Y86 execute-stage datapath. It holds the ALU, the architectural
//            condition-code register {ZF,SF,OF}, jump/cmov condition
//            evaluation and the cmov destination squash.
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            E_icode_i/E_ifun_i  - instruction/function code in E
//            aluA_i/aluB_i/fun_i - ALU operands and ALU function
//            E_dstE_i            - destination register from decode
//            m_stat_i/W_stat_i   - status of the instructions in M and W
//            e_valE_o            - ALU result (combinational)
//            e_cnd_o             - condition result (1 unless JXX/CXX)
//            e_dstE_o            - dstE, forced to RNONE on a failed cmov
//            cc_o                - registered {ZF, SF, OF}
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu_cc #(
    parameter int DATA_WIDTH = 64,
    parameter int STAT_W     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            E_icode_i,
    input  logic [3:0]            E_ifun_i,
    input  logic [DATA_WIDTH-1:0] aluA_i,
    input  logic [DATA_WIDTH-1:0] aluB_i,
    input  logic [3:0]            fun_i,
    input  logic [3:0]            E_dstE_i,
    input  logic [STAT_W-1:0]     m_stat_i,
    input  logic [STAT_W-1:0]     W_stat_i,
    output logic [DATA_WIDTH-1:0] e_valE_o,
    output logic                  e_cnd_o,
    output logic [3:0]            e_dstE_o,
    output logic [2:0]            cc_o
);

    // Instruction codes. CXX shares its encoding with RRMOVQ (unconditional
    // cmov); IXX is the immediate-arithmetic group, whose IRMOVQ member does
    // not touch the flags.
    localparam logic [3:0] c_icode_cxx  = 4'h2;
    localparam logic [3:0] c_icode_opq  = 4'h6;
    localparam logic [3:0] c_icode_jxx  = 4'h7;
    localparam logic [3:0] c_icode_ixx  = 4'hC;
    localparam logic [3:0] c_ifun_irmov = 4'h3;

    localparam logic [3:0] c_alu_add = 4'h0;
    localparam logic [3:0] c_alu_sub = 4'h1;
    localparam logic [3:0] c_alu_and = 4'h2;
    localparam logic [3:0] c_alu_xor = 4'h3;

    localparam logic [STAT_W-1:0] c_stat_aok = STAT_W'(1);
    localparam logic [3:0]        c_rnone    = 4'hF;
    localparam logic [2:0]        c_cc_reset = 3'b100;

    logic [DATA_WIDTH-1:0] w_val_e;
    logic                  w_zf;
    logic                  w_sf;
    logic                  w_of;
    logic                  w_sign_a;
    logic                  w_sign_b;
    logic                  w_set_cc;
    logic                  w_cond;
    logic                  w_lt;
    logic [2:0]            r_cc;

    // ALU; carries fall off the top (modulo 2^DATA_WIDTH)
    always_comb begin
        w_val_e = '0;
        case (fun_i)
            c_alu_add: w_val_e = aluA_i + aluB_i;
            c_alu_sub: w_val_e = aluA_i - aluB_i;
            c_alu_and: w_val_e = aluA_i & aluB_i;
            c_alu_xor: w_val_e = aluA_i ^ aluB_i;
            default:   w_val_e = '0;
        endcase
    end

    assign w_sign_a = aluA_i[DATA_WIDTH-1];
    assign w_sign_b = aluB_i[DATA_WIDTH-1];
    assign w_zf     = (w_val_e == '0);
    assign w_sf     = w_val_e[DATA_WIDTH-1];

    // Signed overflow: the result sign disagrees with aluA's sign while the
    // operand signs make overflow possible (equal for add, differing for sub).
    always_comb begin
        w_of = 1'b0;
        case (fun_i)
            c_alu_add: w_of = (w_sign_a == w_sign_b) && (w_sf != w_sign_a);
            c_alu_sub: w_of = (w_sign_a != w_sign_b) && (w_sf != w_sign_a);
            default:   w_of = 1'b0;
        endcase
    end

    // An excepting instruction further down the pipe blocks the flag write of
    // the instruction currently in E, for this cycle only.
    assign w_set_cc = ((E_icode_i == c_icode_opq) ||
                       ((E_icode_i == c_icode_ixx) && (E_ifun_i != c_ifun_irmov))) &&
                      (m_stat_i == c_stat_aok) && (W_stat_i == c_stat_aok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cc <= c_cc_reset;
        end else if (w_set_cc) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    assign cc_o = r_cc;

    // Conditions read the registered flags, so an instruction never sees
    // the flags it is producing itself.
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cond = 1'b0;
        case (E_ifun_i)
            4'd0:    w_cond = 1'b1;
            4'd1:    w_cond = w_lt | r_cc[2];
            4'd2:    w_cond = w_lt;
            4'd3:    w_cond = r_cc[2];
            4'd4:    w_cond = ~r_cc[2];
            4'd5:    w_cond = ~w_lt;
            4'd6:    w_cond = ~w_lt & ~r_cc[2];
            default: w_cond = 1'b0;
        endcase
    end

    assign e_valE_o = w_val_e;
    assign e_cnd_o  = ((E_icode_i == c_icode_jxx) || (E_icode_i == c_icode_cxx)) ? w_cond : 1'b1;
    assign e_dstE_o = ((E_icode_i == c_icode_cxx) && !w_cond) ? c_rnone : E_dstE_i;

endmodule
`default_nettype wire

// File: doc/exec_alu_cc.md
Name: exec_alu_cc

Overview:
- Execute-stage datapath of the Y86 pipeline, directly downstream of the execute argument selector.
- Consumes the selected operands aluA/aluB and ALU function, then produces e_valE.
- Holds the architectural condition-code register (ZF, SF, OF).
- Evaluates jump and conditional-move conditions and produces e_cnd and the final e_dstE for the E->M pipeline register.

Parameters:
- DATA_WIDTH, 64, operand/result width.
- STAT_W, 4, status code width; AOK encoding per the shared define header.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- E_icode_i  input  4  instruction code in E.
- E_ifun_i  input  4  function code in E.
- aluA_i  input  DATA_WIDTH  first ALU operand.
- aluB_i  input  DATA_WIDTH  second ALU operand.
- fun_i  input  4  ALU function: ADDQ, SUBQ, ANDQ, XORQ, NOPQ.
- E_dstE_i  input  4  destination register ID from decode.
- m_stat_i  input  STAT_W  status of the instruction in M.
- W_stat_i  input  STAT_W  status of the instruction in W.
- e_valE_o  output  DATA_WIDTH  ALU result.
- e_cnd_o  output  1  condition result.
- e_dstE_o  output  4  destination register after conditional-move squash.
- cc_o  output  3  {ZF, SF, OF} register contents.

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high on rst_i.
- ALU, combinational, zero latency:
  - ADDQ: valE = aluA + aluB.
  - SUBQ: valE = aluA - aluB.
  - ANDQ: valE = aluA & aluB.
  - XORQ: valE = aluA ^ aluB.
  - NOPQ or any other code: valE = 0.
  - All results are modulo 2^DATA_WIDTH; the carry is discarded.
- Flags derived from valE:
  - ZF = (valE == 0).
  - SF = valE[MSB].
  - OF for ADDQ: sign(aluA) == sign(aluB) and sign(valE) != sign(aluA).
  - OF for SUBQ: sign(aluA) != sign(aluB) and sign(valE) != sign(aluA).
  - OF = 0 for all other functions.
- set_cc = (E_icode == OPQ, or E_icode == IXX with E_ifun != IRMOVQ) and m_stat == AOK and W_stat == AOK.
- CC register:
  - On a rising edge with rst_i = 1: CC <= {ZF=1, SF=0, OF=0}. Reset has priority over set_cc.
  - Else, if set_cc: CC <= freshly computed flags.
  - Else: hold.
  - Update latency is 1 cycle; an instruction never sees its own flags.
- Condition evaluation is combinational on the registered CC, selected by E_ifun:
  - 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: ~ZF.
  - 5 ge: ~(SF^OF).
  - 6 g: ~(SF^OF)&~ZF.
  - 7-15: 0.
- e_cnd_o is the condition result when E_icode is JXX or CXX; otherwise 1.
- e_dstE_o = RNONE (4'hF) when E_icode == CXX and cnd == 0; otherwise E_dstE_i.
- Back-to-back case: OPQ in cycle n followed by JXX in cycle n+1; the JXX sees the OPQ's flags.
- Bubbles: a bubble in E carries NOP icode. Then set_cc = 0, valE = whatever the operands give, and dstE passes through (RNONE from the bubble).
- Exception suppression: m_stat or W_stat != AOK blocks the CC write for the instruction in E during that cycle only. No state is retained from the suppression.
- Reset outputs: cc_o = 3'b100. e_valE_o, e_cnd_o and e_dstE_o are combinational and follow their inputs in the reset cycle.

Test Plan:
- Reset: rst_i=1 for one edge -> cc_o=3'b100. Then E_icode=JXX, ifun=3 (e) -> e_cnd_o=1; ifun=4 (ne) -> e_cnd_o=0.
- OPQ SUBQ, aluA=5, aluB=5, both stats AOK -> e_valE_o=0 same cycle; cc_o=3'b100 after the edge. Repeat with aluA=3, aluB=5 -> valE=0xFFFF_FFFF_FFFF_FFFE, cc_o=3'b010.
- OPQ ADDQ, aluA=0x7FFF_FFFF_FFFF_FFFF, aluB=1 -> valE=0x8000_0000_0000_0000, cc_o=3'b011. Next cycle JXX ifun=2 (l) -> e_cnd_o=0.
- OPQ with m_stat_i=ADR, or with W_stat_i=HLT, and flags that would change the CC -> cc_o unchanged after the edge. The same op with both AOK -> cc_o updates.
- CXX ifun=3 with ZF=0 and E_dstE_i=4'h2 -> e_cnd_o=0, e_dstE_o=4'hF. After setting ZF=1 -> e_dstE_o=4'h2. CPU-internal ICODE CALL with aluA=0x100, aluB=8, SUBQ -> valE=0xF8, CC unchanged.
- rst_i=1 in the same cycle as a valid OPQ producing cc=3'b010 -> cc_o=3'b100 after the edge (reset wins). Deassert reset and resend -> 3'b010.
